apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator between the multicycle RISC-V CPU data bus and the APB peripherals (UART, GPIO, timers).
//  Decodes the CPU address, drives the APB SETUP/ACCESS sequence to one of 4 slaves and waits for that slave's PREADY.
//  Returns read data and a one-cycle completion pulse to the CPU.
// PARAMETERS
//  BASE_HI        16'h1000  required value of cpu_addr[31:16] for a valid APB access
//  TIMEOUT_CYCLES 16        ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN
// PORTS
//  PCLK        in   1   single clock, all logic on rising edge
//  PRESET      in   1   asynchronous active-high reset
//  cpu_req     in   1   transfer request; sampled only in IDLE
//  cpu_we      in   1   1=write, 0=read; sampled with cpu_req
//  cpu_addr    in   32  byte address; sampled with cpu_req
//  cpu_wdata   in   32  write data; sampled with cpu_req
//  cpu_rdata   out  32  read data; valid while cpu_ready=1
//  cpu_ready   out  1   one-cycle completion pulse
//  cpu_err     out  1   error flag; valid while cpu_ready=1
//  PADDR       out  32  latched cpu_addr
//  PWDATA      out  32  latched cpu_wdata
//  PWRITE      out  1   latched cpu_we
//  PSEL        out  4   one-hot slave select
//  PENABLE     out  1   APB access phase
//  PRDATA0..3  in   32  per-slave read data
//  PREADY0..3  in   1   per-slave ready
// BEHAVIOUR
//  Reset: all outputs 0 asynchronously. FSM goes to IDLE. A transfer in progress is dropped with no completion pulse.
//  Decode: valid when cpu_addr[31:16]==BASE_HI and cpu_addr[15:12]<4. The slave index is cpu_addr[15:12].
//  FSM states: IDLE, SETUP, ACCESS, DONE.
//   IDLE:
//    - cpu_req=1 and valid: latch addr/wdata/we into PADDR/PWDATA/PWRITE. Next cycle -> SETUP.
//    - cpu_req=1 and invalid: no PSEL. -> DONE with err=1, rdata=0.
//   SETUP: PSEL[idx]=1, PENABLE=0 for exactly 1 cycle. -> ACCESS.
//   ACCESS:
//    - PSEL[idx]=1, PENABLE=1.
//    - On a cycle with PREADY[idx]=1: capture PRDATA[idx] (reads only; writes capture 0). -> DONE.
//    - PREADY of unselected slaves is ignored.
//   DONE:
//    - PSEL=0, PENABLE=0, cpu_ready=1 for 1 cycle, cpu_rdata and cpu_err valid. -> IDLE.
//    - cpu_rdata holds its value until the next completion. cpu_err and cpu_ready are 0 outside DONE.
//  Latency: req -> cpu_ready = 3 + W cycles (W = ACCESS wait cycles before PREADY). Decode error: 1 cycle.
//  Ready at ACCESS entry (W=0): PENABLE is high for exactly 1 cycle.
//  PADDR, PWDATA and PWRITE stay stable from SETUP through ACCESS. They keep their value in IDLE and DONE.
//  cpu_req while not IDLE is ignored, not queued. A new transfer is accepted in IDLE the cycle after DONE (back-to-back).
//  PSEL is never multi-hot. PENABLE=1 only in ACCESS.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - A counter starts at 0 on ACCESS entry.
//   - If PREADY[idx] is still 0 when the count reaches TIMEOUT_CYCLES-1: drop PSEL/PENABLE, -> DONE with err=1, rdata=0.
//   - PREADY on that same cycle takes precedence: normal completion, err=0.
//  APB_TIMEOUT_EN undefined: ACCESS waits indefinitely. cpu_err is set only by decode error. No counter logic.
// TESTING
//  1. Write 0x10000004 data 0x41, slave0 PREADY the cycle after PENABLE -> PSEL=4'b0001 setup, PWRITE=1, cpu_ready 4 cycles after req, err=0.
//  2. Read 0x10001008, slave1 PRDATA=0xCAFE_F00D, 3 wait cycles -> PSEL=4'b0010, cpu_rdata=0xCAFEF00D, latency 6, PENABLE high 4 cycles.
//  3. Read 0x20000000, then 0x10005000 -> each: cpu_ready 1 cycle after req, err=1, rdata=0, PSEL stays 0.
//  4. Back-to-back: writes to slaves 2 then 3, second req held high -> second SETUP starts 1 cycle after first cpu_ready; PADDR stable per phase.
//  5. PRESET asserted during ACCESS -> all outputs 0 immediately, no cpu_ready; next req completes normally.
//  6. APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY never set -> err=1, rdata=0 after 16 ACCESS cycles. Without the macro: still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Bus bundle between the CPU data port, the APB initiator and the four APB slaves.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if;
    // CPU side
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    // APB side
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator bridging the CPU data bus to four APB slaves (SETUP/ACCESS sequencing,
// address decode, one-cycle completion pulse).
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES cycles.
module apb_master_bridge #(
    parameter logic [15:0] BASE_HI        = 16'h1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        addr_valid;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    // A zero limit would make the abort compare wrap; reject it at elaboration.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // Slave window: upper half must match BASE_HI, only slave indices 0..3 exist.
    assign addr_valid = (bus.cpu_addr[31:16] == BASE_HI) && (bus.cpu_addr[15:14] == 2'b00);

    // Route only the selected slave's response; the others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        unique case (idx_q)
            2'd0: begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
            2'd1: begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
            2'd2: begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
            2'd3: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
            default: ;
        endcase
    end

    // Next-state logic for the transfer FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    if (addr_valid) begin
                        paddr_d  = bus.cpu_addr;
                        pwdata_d = bus.cpu_wdata;
                        pwrite_d = bus.cpu_we;
                        idx_d    = bus.cpu_addr[13:12];
                        state_d  = StSetup;
                    end else begin
                        // Decode miss: complete immediately without touching the APB.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StSetup: begin
`ifdef APB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = StAccess;
            end
            StAccess: begin
                if (sel_ready) begin
                    err_d   = 1'b0;
                    rdata_d = pwrite_q ? 32'd0 : sel_rdata;
                    state_d = StDone;
`ifdef APB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS-phase cycle counter.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Outputs decoded from state so that reset clears them without a clock edge.
    always_comb begin
        bus.PADDR     = paddr_q;
        bus.PWDATA    = pwdata_q;
        bus.PWRITE    = pwrite_q;
        bus.PSEL      = ((state_q == StSetup) || (state_q == StAccess)) ? (4'b0001 << idx_q) : 4'b0000;
        bus.PENABLE   = (state_q == StAccess);
        bus.cpu_ready = (state_q == StDone);
        bus.cpu_err   = (state_q == StDone) && err_q;
        bus.cpu_rdata = rdata_q;
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model of decode, latency and completion data.
module tb_apb_master_bridge;

    localparam int unsigned Tmo = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_master_bridge_if bus ();

    apb_master_bridge dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Slave behaviour: wait w cycles of PENABLE before PREADY; unselected slaves show noise.
    logic [31:0] s_rdata [4];
    int unsigned s_wait  [4];
    logic [3:0]  noise;
    int unsigned acc_cnt;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) acc_cnt <= 0;
        else        acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
    end

    always_comb begin
        bus.PRDATA0 = s_rdata[0];
        bus.PRDATA1 = s_rdata[1];
        bus.PRDATA2 = s_rdata[2];
        bus.PRDATA3 = s_rdata[3];
        bus.PREADY0 = (bus.PSEL[0] && bus.PENABLE) ? (acc_cnt >= s_wait[0]) : noise[0];
        bus.PREADY1 = (bus.PSEL[1] && bus.PENABLE) ? (acc_cnt >= s_wait[1]) : noise[1];
        bus.PREADY2 = (bus.PSEL[2] && bus.PENABLE) ? (acc_cnt >= s_wait[2]) : noise[2];
        bus.PREADY3 = (bus.PSEL[3] && bus.PENABLE) ? (acc_cnt >= s_wait[3]) : noise[3];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    function automatic bit dec_ok(input logic [31:0] a);
        return (a[31:16] == 16'h1000) && (a[15:12] < 4'd4);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"},   bus.PSEL,      0);
        chk({tag, "_pen"},    bus.PENABLE,   0);
        chk({tag, "_paddr"},  bus.PADDR,     0);
        chk({tag, "_pwdata"}, bus.PWDATA,    0);
        chk({tag, "_pwrite"}, bus.PWRITE,    0);
        chk({tag, "_ready"},  bus.cpu_ready, 0);
        chk({tag, "_err"},    bus.cpu_err,   0);
        chk({tag, "_rdata"},  bus.cpu_rdata, 0);
    endtask

    // One CPU transfer. preload: req already held high from the previous transfer.
    // chain: keep req high with the next transfer's fields once this one is under way.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit preload, input bit chain, input logic nwe,
                           input logic [31:0] naddr, input logic [31:0] nwdata);
        bit          ok;
        bit          tmo;
        bit          seen;
        int unsigned idx;
        int unsigned w;
        int unsigned exp_lat;
        int unsigned exp_pen;
        int unsigned pen;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_sel;
        ok   = dec_ok(addr);
        idx  = int'(addr[13:12]);
        w    = s_wait[idx];
        tmo  = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo  = ok && (w >= Tmo);
`endif
        exp_sel = ok ? 4'(1 << idx) : 4'b0000;
        exp_err = !ok || tmo;
        exp_rd  = (ok && !we && !tmo) ? s_rdata[idx] : 32'd0;
        exp_lat = !ok ? 1 : (tmo ? 2 + Tmo : 3 + w);
        exp_pen = !ok ? 0 : (tmo ? Tmo : w + 1);
        pen  = 0;
        seen = 1'b0;
        if (preload) begin
            step();
            chk("b2b_idle_psel",  bus.PSEL,      0);
            chk("b2b_idle_ready", bus.cpu_ready, 0);
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        step();
        if (chain) begin
            bus.cpu_we    = nwe;
            bus.cpu_addr  = naddr;
            bus.cpu_wdata = nwdata;
        end else begin
            bus.cpu_req   = 1'b0;
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = $urandom;
            bus.cpu_wdata = $urandom;
        end
        for (int n = 1; n <= 300 && !seen; n++) begin
            chk("psel_legal", (bus.PSEL == 4'b0000) || (bus.PSEL == exp_sel), 1);
            if (bus.PENABLE) begin
                pen++;
                chk("pen_needs_psel", bus.PSEL, exp_sel);
            end
            if (bus.PSEL != 4'b0000) begin
                chk("paddr_stable",  bus.PADDR,  addr);
                chk("pwdata_stable", bus.PWDATA, wdata);
                chk("pwrite_stable", bus.PWRITE, we);
            end
            if (n == 1 && ok) begin
                chk("setup_psel", bus.PSEL,    exp_sel);
                chk("setup_pen",  bus.PENABLE, 0);
            end
            if (bus.cpu_ready) begin
                seen = 1'b1;
                chk("latency",   n,             exp_lat);
                chk("err",       bus.cpu_err,   exp_err);
                chk("rdata",     bus.cpu_rdata, exp_rd);
                chk("pen_count", pen,           exp_pen);
                chk("done_psel", bus.PSEL,      0);
                chk("done_pen",  bus.PENABLE,   0);
                if (ok) chk("done_paddr", bus.PADDR, addr);
            end else begin
                chk("err_outside_done", bus.cpu_err, 0);
                step();
            end
        end
        chk("ready_seen", seen, 1);
        if (seen && !chain) begin
            step();
            chk("ready_one_cycle", bus.cpu_ready, 0);
            chk("rdata_held",      bus.cpu_rdata, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] a;
        PRESET        = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        noise         = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            s_rdata[i] = 32'h1111_1111 * (i + 1);
            s_wait[i]  = 0;
        end

        // Reset state
        repeat (2) step();
        chk_all_zero("reset");
        PRESET = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Write to slave 0, ready one cycle after PENABLE
        s_wait[0] = 1;
        do_xfer(1'b1, 32'h1000_0004, 32'h41, 0, 0, 0, 0, 0);

        // Decode errors: wrong base, then slave index out of range
        noise = 4'b1111;
        do_xfer(1'b0, 32'h2000_0000, 32'h0, 0, 0, 0, 0, 0);
        do_xfer(1'b0, 32'h1000_5000, 32'h0, 0, 0, 0, 0, 0);

        // Back-to-back writes to slaves 2 and 3, second request held high
        noise     = 4'b0000;
        s_wait[2] = 0;
        s_wait[3] = 2;
        do_xfer(1'b1, 32'h1000_2004, 32'h22, 0, 1, 1'b1, 32'h1000_300C, 32'h33);
        do_xfer(1'b1, 32'h1000_300C, 32'h33, 1, 0, 0, 0, 0);

        // Read slave 1 with 3 wait cycles; other slaves keep asserting PREADY
        noise      = 4'b1101;
        s_rdata[1] = 32'hCAFE_F00D;
        s_wait[1]  = 3;
        do_xfer(1'b0, 32'h1000_1008, 32'h0, 0, 0, 0, 0, 0);

        // Reset during ACCESS drops the transfer
        noise     = 4'b0000;
        s_wait[2] = 1000;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h1000_2010;
        bus.cpu_wdata = 32'h5A5A_0000;
        step();
        bus.cpu_req = 1'b0;
        step();
        chk("rst_mid_access_pen", bus.PENABLE, 1);
        #2 PRESET = 1'b1;
        #1 chk_all_zero("async_reset");
        step();
        chk("reset_no_ready", bus.cpu_ready, 0);
        step();
        PRESET    = 1'b0;
        s_wait[2] = 0;
        s_rdata[2] = 32'h0BAD_BEEF;
        do_xfer(1'b0, 32'h1000_2010, 32'h0, 0, 0, 0, 0, 0);

        // Slave that never becomes ready
        s_wait[3] = 1000;
`ifdef APB_TIMEOUT_EN
        do_xfer(1'b0, 32'h1000_3000, 32'h0, 0, 0, 0, 0, 0);
`else
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h1000_3000;
        bus.cpu_wdata = 32'h0;
        step();
        bus.cpu_req = 1'b0;
        repeat (101) step();
        chk("no_tmo_pen",   bus.PENABLE,   1);
        chk("no_tmo_psel",  bus.PSEL,      4'b1000);
        chk("no_tmo_ready", bus.cpu_ready, 0);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        step();
`endif

        // Randomized transfers against the transaction model
        for (int t = 0; t < 40; t++) begin
            a = {16'h1000, 4'($urandom_range(0, 5)), 12'($urandom)};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            for (int i = 0; i < 4; i++) begin
                s_rdata[i] = $urandom;
                s_wait[i]  = $urandom_range(0, 5);
            end
            noise = 4'($urandom);
            do_xfer(1'($urandom), a, $urandom, 0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
